// File: rtl/code_decoder_2to4.sv
// Sequential 2-to-4 line decoder: {x,y} code to one-hot {a,b,c,d}, through a
// 2-entry valid/ready buffer, with saturating per-line delivery counters.
module code_decoder_2to4 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             x,
    input  logic             y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             clr_cnt,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_val
);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    // Same code map as the upstream 4-to-2 encoder; bit 3 is line a.
    function automatic logic [3:0] decode_code(input logic [1:0] code);
        logic [3:0] word;
        case (code)
            2'b11:   word = 4'b1000;
            2'b10:   word = 4'b0100;
            2'b01:   word = 4'b0010;
            2'b00:   word = 4'b0001;
            default: word = 4'b0000;
        endcase
        return word;
    endfunction

    logic [1:0] occ_r;
    logic [3:0] head_r;
    logic [3:0] tail_r;
    cnt_t       cnt_r [4];

    logic [1:0] occ_nxt_s;
    logic [3:0] head_nxt_s;
    logic [3:0] tail_nxt_s;
    logic       push_s;
    logic       pop_s;
    logic [3:0] new_word_s;
    logic [3:0] line_hit_s;

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready  = (occ_r < 2'd2);
    assign out_valid = (occ_r != 2'd0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign new_word_s = decode_code({x, y});

    // The head register is kept at zero whenever the buffer is empty, so the
    // outputs come straight from flops with no empty-masking logic.
    assign a = head_r[3];
    assign b = head_r[2];
    assign c = head_r[1];
    assign d = head_r[0];

    // Buffer next-state: head/tail shift structure with occupancy 0..2.
    always_comb begin
        occ_nxt_s  = occ_r;
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        case (occ_r)
            2'd0: begin
                if (push_s) begin
                    occ_nxt_s  = 2'd1;
                    head_nxt_s = new_word_s;
                end else begin
                    head_nxt_s = 4'b0000;
                    tail_nxt_s = 4'b0000;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_nxt_s = new_word_s;
                end else if (push_s) begin
                    occ_nxt_s  = 2'd2;
                    tail_nxt_s = new_word_s;
                end else if (pop_s) begin
                    occ_nxt_s  = 2'd0;
                    head_nxt_s = 4'b0000;
                end else begin
                    head_nxt_s = head_r;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    occ_nxt_s  = 2'd1;
                    head_nxt_s = tail_r;
                    tail_nxt_s = 4'b0000;
                end else begin
                    head_nxt_s = head_r;
                end
            end
            default: begin
                occ_nxt_s  = 2'd0;
                head_nxt_s = 4'b0000;
                tail_nxt_s = 4'b0000;
            end
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_r  <= 2'd0;
            head_r <= 4'b0000;
            tail_r <= 4'b0000;
        end else begin
            occ_r  <= occ_nxt_s;
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
        end
    end

    // Counter index i follows cnt_sel numbering (0=a .. 3=d).
    assign line_hit_s = {head_r[0], head_r[1], head_r[2], head_r[3]} & {4{pop_s}};

    // Delivery counters: clear beats a coincident pop; saturate at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (line_hit_s[i] && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + cnt_t'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Combinational counter read port.
    always_comb begin
        cnt_val = '0;
        case (cnt_sel)
            2'd0:    cnt_val = cnt_r[0];
            2'd1:    cnt_val = cnt_r[1];
            2'd2:    cnt_val = cnt_r[2];
            2'd3:    cnt_val = cnt_r[3];
            default: cnt_val = '0;
        endcase
    end

endmodule

// File: tb/tb_code_decoder_2to4.sv
// Scoreboard bench for code_decoder_2to4: directed plan sequences followed by
// random traffic, checked against a queue/array reference model.
module tb_code_decoder_2to4;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             y;
    logic             out_valid;
    logic             out_ready;
    logic             a, b, c, d;
    logic             clr_cnt;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_val;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] exp_q[$];
    int         exp_cnt [4];

    bit         pend;
    logic [3:0] pend_word;

    code_decoder_2to4 #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .d(d),
        .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Code value k selects line 3-k; line 0 (a) is the MSB of the word.
    function automatic logic [3:0] ref_word(input int code);
        return 4'(8 >> (3 - code));
    endfunction

    // Monitor: sample mid-cycle, compare to model, then apply the upcoming edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
            end else begin
                check("cnt_val", int'(cnt_val), exp_cnt[cnt_sel]);
                check("out_valid", int'(out_valid), int'(exp_q.size() > 0));
                check("in_ready", int'(in_ready), int'(exp_q.size() < 2));
                if (exp_q.size() > 0) check("word", int'({a, b, c, d}), int'(exp_q[0]));
                else                  check("empty_word", int'({a, b, c, d}), 0);
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    logic [3:0] w;
                    w = exp_q.pop_front();
                    for (int i = 0; i < 4; i++)
                        if (w == ref_word(3 - i) && exp_cnt[i] < CMAX) exp_cnt[i]++;
                end
                if (clr_cnt) for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
            end
        end
    end

    // One stimulus cycle; a handshake is committed to the model once its edge passed.
    task automatic cyc(input bit iv, input int code, input bit ordy,
                       input bit clr, input int sel, input bit rn);
        @(posedge clk);
        #1;
        if (pend) exp_q.push_back(pend_word);
        rst_n     = rn;
        in_valid  = iv;
        {x, y}    = 2'(code);
        out_ready = ordy;
        clr_cnt   = clr;
        cnt_sel   = 2'(sel);
        pend      = iv && in_ready && rn;
        pend_word = ref_word(code);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x = 1'b0; y = 1'b0;
        out_ready = 1'b0; clr_cnt = 1'b0; cnt_sel = 2'd0;
        pend = 1'b0; pend_word = 4'b0000;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // map sweep, then read back every counter
        for (int k = 3; k >= 0; k--) cyc(1, k, 1, 0, 0, 1);
        for (int s = 0; s < 4; s++) cyc(0, 0, 1, 0, s, 1);
        cyc(0, 0, 1, 0, 0, 1);
        for (int s = 0; s < 4; s++) begin
            n_chk++;
            if (exp_cnt[s] != 1) begin
                n_fail++;
                $display("FAIL sweep_cnt%0d: model %0d, expected 1", s, exp_cnt[s]);
            end
        end

        // backpressure: two pushes fill, third offer refused, then drain
        cyc(1, 3, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 3, 1);
        cyc(0, 0, 1, 0, 3, 1);

        // simultaneous push/pop at occupancy 1
        cyc(1, 2, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) cyc(1, k % 4, 1, 0, 1, 1);
        cyc(0, 0, 1, 0, 1, 1);
        cyc(0, 0, 1, 0, 1, 1);

        // saturation of counter c, others cleared first
        cyc(0, 0, 1, 1, 0, 1);
        for (int k = 0; k < 5; k++) cyc(1, 1, 1, 0, 2, 1);
        for (int s = 0; s < 4; s++) cyc(0, 0, 1, 0, s, 1);
        cyc(0, 0, 1, 0, 2, 1);

        // clear colliding with a pop of code 10
        cyc(1, 2, 0, 0, 1, 1);
        cyc(0, 0, 1, 1, 1, 1);
        cyc(0, 0, 1, 0, 1, 1);

        // reset with two words buffered
        cyc(1, 3, 0, 0, 0, 1);
        cyc(1, 2, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 0);
        for (int s = 0; s < 4; s++) cyc(0, 0, 0, 0, s, 1);

        // random traffic
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(99) < 70, $urandom_range(3), $urandom_range(99) < 60,
                $urandom_range(99) < 3, $urandom_range(3), $urandom_range(199) != 0);

        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, k, 1);
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
